// File: rtl/pa_mem_arb.sv
// rtl/pa_mem_arb.sv - round-robin burst arbiter sharing one memory port among W, D and R requesters
module pa_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [LEN_W-1:0]  w_len,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  input  logic              r_req,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [LEN_W-1:0]  r_len,
  output logic              w_gnt,
  output logic              d_gnt,
  output logic              r_gnt,
  output logic              w_beat,
  output logic              d_beat,
  output logic              r_beat,
  output logic              w_done,
  output logic              d_done,
  output logic              r_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_src,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        owner, rr, pick;
  logic [ADDR_W-1:0] addr, sel_addr;
  logic [LEN_W-1:0]  sel_len, last_idx, cnt;
  logic [2:0]        own_oh, gnt_v, beat_v, done_v;
  logic              any_req, beat_ok, last_beat;

  assign any_req   = w_req | d_req | r_req;
  assign beat_ok   = (state == BURST) && mem_ready;
  assign last_beat = (cnt == last_idx);
  assign own_oh    = 3'b001 << owner;

  // Search starts at the round-robin pointer and wraps W -> D -> R -> W
  always_comb begin
    pick = 2'd0;
    case (rr)
      2'd1:    pick = d_req ? 2'd1 : (r_req ? 2'd2 : 2'd0);
      2'd2:    pick = r_req ? 2'd2 : (w_req ? 2'd0 : 2'd1);
      default: pick = w_req ? 2'd0 : (d_req ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    sel_addr = w_addr;
    sel_len  = w_len;
    case (pick)
      2'd1:    begin sel_addr = d_addr; sel_len = d_len; end
      2'd2:    begin sel_addr = r_addr; sel_len = r_len; end
      default: begin sel_addr = w_addr; sel_len = w_len; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BURST;
      BURST:   if (beat_ok && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Base and length are captured at grant; a zero length runs as one beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 2'd0;
      rr       <= 2'd0;
      addr     <= '0;
      cnt      <= '0;
      last_idx <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          owner    <= pick;
          addr     <= sel_addr;
          cnt      <= '0;
          last_idx <= (sel_len == '0) ? '0 : sel_len - LEN_W'(1);
        end
        BURST: if (beat_ok && !last_beat) begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt + LEN_W'(1);
        end
        DONE: rr <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt_v     = 3'b000;
    beat_v    = 3'b000;
    done_v    = 3'b000;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_src   = 2'd3;
    case (state)
      BURST: begin
        gnt_v     = own_oh;
        beat_v    = mem_ready ? own_oh : 3'b000;
        mem_valid = 1'b1;
        mem_we    = (owner == 2'd2);
        mem_src   = owner;
      end
      DONE:    done_v = own_oh;
      default: ;
    endcase
  end

  assign mem_addr = addr;
  assign busy     = (state != IDLE);
  assign {r_gnt, d_gnt, w_gnt}    = gnt_v;
  assign {r_beat, d_beat, w_beat} = beat_v;
  assign {r_done, d_done, w_done} = done_v;

endmodule

// File: doc/pa_mem_arb.md
Name: pa_mem_arb

Overview:
- Burst arbiter sharing one on-chip memory port among the three PE-array traffic classes: weight read (W), data read (D) and result write (R).
- Sits between the PE-array sequencer's handshake outputs and the SRAM/bus interface.
- Grants whole bursts with round-robin fairness and generates per-beat addresses.
- Reports beat and completion events back to each requester.

Parameters:
ADDR_W, 32, memory address width; addresses wrap modulo 2^ADDR_W
LEN_W, 10, burst length field width in beats

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
w_req  in  1  weight-read burst request
w_addr  in  ADDR_W  weight burst base address
w_len  in  LEN_W  weight burst length in beats
d_req  in  1  data-read burst request
d_addr  in  ADDR_W  data burst base address
d_len  in  LEN_W  data burst length in beats
r_req  in  1  result-write burst request
r_addr  in  ADDR_W  result burst base address
r_len  in  LEN_W  result burst length in beats
w_gnt / d_gnt / r_gnt  out  1 each  requester owns the port (level, whole burst)
w_beat / d_beat / r_beat  out  1 each  pulse: one beat accepted this cycle
w_done / d_done / r_done  out  1 each  pulse: burst finished
mem_valid  out  1  beat presented to memory
mem_ready  in  1  memory accepts beat
mem_addr  out  ADDR_W  beat address
mem_we  out  1  1 = write (R burst), 0 = read
mem_src  out  2  owner: 0 = W, 1 = D, 2 = R, 3 = none
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all gnt/beat/done = 0; mem_valid = 0; mem_addr = 0; mem_we = 0; mem_src = 3; busy = 0; RR pointer = W (priority order W > D > R).
- States:
  - IDLE: on any req high, pick the winner, latch addr/len, assert its gnt, go to BURST. No req: stay.
  - BURST: mem_valid = 1. A beat completes when mem_valid & mem_ready.
    - Non-last beat: mem_addr += 1; beat counter += 1.
    - Last beat (counter == len-1): go to DONE.
  - DONE: one cycle. done pulse for the owner; gnt, mem_valid and mem_src = 3 deasserted this cycle; RR pointer moves to the requester after the winner; go to IDLE.
- Latency:
  - req sampled high in cycle N: gnt and mem_valid high from N+1; first beat address = latched base.
  - Minimum burst turnaround = 2 idle cycles (DONE + IDLE) between bursts.
- Arbitration:
  - Search order starts at the RR pointer and wraps W -> D -> R -> W.
  - Simultaneous requests: the first in that order wins.
  - Requests arriving mid-burst wait; no preemption.
- Handshake:
  - mem_valid, mem_addr, mem_we and mem_src are stable while mem_valid & !mem_ready (backpressure holds everything).
  - beat pulse equals mem_valid & mem_ready for the owner.
- len == 0 is treated as 1 beat.
- Length and address inputs are latched at grant; later changes are ignored until the next grant.
- req deassert mid-burst is ignored; the burst runs to completion. Requesters hold req until done, then drop it for at least 1 cycle. A req still high in IDLE after its done is a new request.
- Address increment wraps at 2^ADDR_W (all-ones + 1 = 0).
- Reset mid-burst: immediate return to reset values; no done pulse.

Test Plan:
- Single W burst, addr=0x100, len=4, mem_ready=1: w_gnt from N+1; mem_addr 0x100..0x103 on 4 consecutive cycles; mem_we=0; w_done one cycle after the 4th beat; busy low after IDLE.
- W, D, R all requesting at reset, len=2 each: grant order W, D, R; after R finishes with W still requesting, W wins again; r bursts show mem_we=1, mem_src=2.
- Backpressure: D burst len=3, mem_ready toggling 1,0,0,1,1: mem_addr holds through stall cycles; exactly 3 d_beat pulses; d_done once.
- len=0 and wrap: R addr=0xFFFFFFFF, len=2 -> beats at 0xFFFFFFFF then 0x00000000; then R len=0 -> exactly 1 beat.
- Mid-burst request: W len=8 running, D asserts at beat 3 -> W completes all 8 beats, then D granted 2 cycles after w_done.
- Reset mid-burst: rst_n low at beat 2 of a W len=5 burst -> all outputs return to reset values asynchronously, no w_done; after release with D and W both requesting, W wins.
